// File: rtl/swap_wb_ctrl.sv
// -----------------------------------------------------------------------------
// swap_wb_ctrl
//
// Purpose:
//    Sequences a two-register swap through a single register-file write port.
//    When a swap is requested, both operand addresses and both operand values
//    are captured. Two back-to-back write-back cycles follow:
//       rs <- old rt, then rt <- old rs.
//    The capture is required because the first write overwrites rs in the
//    register file before the second write happens.
//
// Ports:
//    clk      in   1       system clock, rising edge
//    rst_f    in   1       synchronous active-low reset
//    start    in   1       swap request, sampled only while idle
//    rs_addr  in   ADDR_W  first register address
//    rt_addr  in   ADDR_W  second register address
//    rs_data  in   DATA_W  current contents of rs, valid with start
//    rt_data  in   DATA_W  current contents of rt, valid with start
//    busy     out  1       high while a swap is in progress
//    done     out  1       one-cycle completion pulse
//    out_sel  out  1       swap data mux select: 1 = rt data, 0 = rs data
//    wb_en    out  1       register-file write enable
//    wb_addr  out  ADDR_W  register-file write address
//    wb_data  out  DATA_W  register-file write data
//
// Build option:
//    SWAP_PROTECT_R0_EN - when defined, any write-back cycle addressed to
//    register 0 keeps wb_en low. Address, data, select and state timing are
//    unaffected.
// -----------------------------------------------------------------------------
module swap_wb_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              start,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              busy,
   output logic              done,
   output logic              out_sel,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_RS = 2'd1,
      WR_RT = 2'd2,
      DONE  = 2'd3
   } state_t;

`ifdef SWAP_PROTECT_R0_EN
   localparam logic PROTECT_R0 = 1'b1;
`else
   localparam logic PROTECT_R0 = 1'b0;
`endif

   // Decides whether a write-back cycle to the given address may pulse wb_en.
   function automatic logic wr_allowed(input logic [ADDR_W-1:0] addr);
      return !(PROTECT_R0 && (addr == {ADDR_W{1'b0}}));
   endfunction

   state_t            state_r,   state_s;
   logic [ADDR_W-1:0] rs_addr_r, rs_addr_s;
   logic [ADDR_W-1:0] rt_addr_r, rt_addr_s;
   logic [DATA_W-1:0] rs_data_r, rs_data_s;
   logic [DATA_W-1:0] rt_data_r, rt_data_s;

   logic              busy_r,    busy_s;
   logic              done_r,    done_s;
   logic              out_sel_r, out_sel_s;
   logic              wb_en_r,   wb_en_s;
   logic [ADDR_W-1:0] wb_addr_r, wb_addr_s;
   logic [DATA_W-1:0] wb_data_r, wb_data_s;

   // Next-state and snapshot capture logic.
   always_comb begin
      state_s   = state_r;
      rs_addr_s = rs_addr_r;
      rt_addr_s = rt_addr_r;
      rs_data_s = rs_data_r;
      rt_data_s = rt_data_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               rs_addr_s = rs_addr;
               rt_addr_s = rt_addr;
               rs_data_s = rs_data;
               rt_data_s = rt_data;
               // A swap of a register with itself changes nothing, so skip
               // straight to the completion pulse.
               if (rs_addr == rt_addr) begin
                  state_s = DONE;
               end else begin
                  state_s = WR_RS;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WR_RS:   state_s = WR_RT;
         WR_RT:   state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the registered outputs line
   // up with the state they describe during the following cycle.
   always_comb begin
      busy_s    = 1'b0;
      done_s    = 1'b0;
      out_sel_s = 1'b0;
      wb_en_s   = 1'b0;
      wb_addr_s = {ADDR_W{1'b0}};
      wb_data_s = {DATA_W{1'b0}};
      case (state_s)
         IDLE: begin
            busy_s = 1'b0;
         end
         WR_RS: begin
            busy_s    = 1'b1;
            out_sel_s = 1'b1;
            wb_en_s   = wr_allowed(rs_addr_s);
            wb_addr_s = rs_addr_s;
            wb_data_s = rt_data_s;
         end
         WR_RT: begin
            busy_s    = 1'b1;
            out_sel_s = 1'b0;
            wb_en_s   = wr_allowed(rt_addr_s);
            wb_addr_s = rt_addr_s;
            wb_data_s = rs_data_s;
         end
         DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, snapshot and output registers; reset aborts any swap in flight.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_r   <= IDLE;
         rs_addr_r <= {ADDR_W{1'b0}};
         rt_addr_r <= {ADDR_W{1'b0}};
         rs_data_r <= {DATA_W{1'b0}};
         rt_data_r <= {DATA_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         out_sel_r <= 1'b0;
         wb_en_r   <= 1'b0;
         wb_addr_r <= {ADDR_W{1'b0}};
         wb_data_r <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_s;
         rs_addr_r <= rs_addr_s;
         rt_addr_r <= rt_addr_s;
         rs_data_r <= rs_data_s;
         rt_data_r <= rt_data_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         out_sel_r <= out_sel_s;
         wb_en_r   <= wb_en_s;
         wb_addr_r <= wb_addr_s;
         wb_data_r <= wb_data_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign out_sel = out_sel_r;
   assign wb_en   = wb_en_r;
   assign wb_addr = wb_addr_r;
   assign wb_data = wb_data_r;

endmodule

// File: tb/tb_swap_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_swap_wb_ctrl
//
// Scoreboard bench for swap_wb_ctrl. The stimulus process predicts, for every
// accepted swap, the list of write-back and completion events with the clock
// edge after which each must be visible, and pushes them into a queue. A
// separate monitor pops and compares whenever the DUT shows wb_en or done,
// and checks busy against the predicted busy window every cycle.
// -----------------------------------------------------------------------------
module tb_swap_wb_ctrl;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int MAX_EDGES = 4096;

   logic              clk;
   logic              rst_f;
   logic              start;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              busy;
   logic              done;
   logic              out_sel;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   swap_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst_f   (rst_f),
      .start   (start),
      .rs_addr (rs_addr),
      .rt_addr (rt_addr),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .out_sel (out_sel),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit                is_done;
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      bit                sel;
   } ev_t;

   ev_t q[$];
   bit  exp_busy[0:MAX_EDGES-1];
   int  edge_cnt = 0;
   int  ready    = 0;   // first edge at which a new start is accepted
   int  vectors  = 0;
   int  errors   = 0;
   bit  mon_en   = 1'b0;

`ifdef SWAP_PROTECT_R0_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   function automatic void push_wr(int k, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, bit s);
      ev_t e;
      e.is_done = 1'b0; e.cyc = k; e.addr = a; e.data = d; e.sel = s;
      if (!(PROT && a == 4'd0)) q.push_back(e);
   endfunction

   function automatic void push_done(int k);
      ev_t e;
      e.is_done = 1'b1; e.cyc = k; e.addr = '0; e.data = '0; e.sel = 1'b0;
      q.push_back(e);
   endfunction

   // Reference: what a swap request at edge k must cause, in plain terms.
   function automatic void model(int k, bit s, bit rf,
                                 logic [ADDR_W-1:0] a1, logic [ADDR_W-1:0] a2,
                                 logic [DATA_W-1:0] d1, logic [DATA_W-1:0] d2);
      if (!rf) begin
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc >= k) q.delete(i);
         ready = k + 1;
      end else if (s && k >= ready) begin
         if (a1 == a2) begin
            push_done(k);
            ready = k + 2;
         end else begin
            push_wr(k, a1, d2, 1'b1);       // rs gets old rt
            push_wr(k + 1, a2, d1, 1'b0);   // rt gets old rs
            push_done(k + 2);
            ready = k + 4;
         end
      end
      exp_busy[k] = (k <= ready - 2);
   endfunction

   task automatic cyc(bit s, bit rf, logic [ADDR_W-1:0] a1, logic [ADDR_W-1:0] a2,
                      logic [DATA_W-1:0] d1, logic [DATA_W-1:0] d2);
      start = s; rst_f = rf; rs_addr = a1; rt_addr = a2; rs_data = d1; rt_data = d2;
      model(edge_cnt + 1, s, rf, a1, a2, d1, d2);
      @(posedge clk);
      edge_cnt++;
      #2;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'd0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
      end
   endtask

   // Monitor: observes outputs on the falling edge, away from updates.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy[edge_cnt]});
            while (q.size() > 0 && q[0].cyc < edge_cnt) begin
               vectors++; errors++;
               $display("FAIL missed_event expected at edge %0d got nothing (is_done=%0d)",
                        q[0].cyc, q[0].is_done);
               void'(q.pop_front());
            end
            if (wb_en === 1'b1 || done === 1'b1) begin
               if (q.size() > 0 && q[0].cyc == edge_cnt) begin
                  ev_t e;
                  e = q.pop_front();
                  chk("done", {31'd0, done}, {31'd0, e.is_done});
                  chk("wb_en", {31'd0, wb_en}, {31'd0, !e.is_done});
                  if (!e.is_done) begin
                     chk("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
                     chk("wb_data", wb_data, e.data);
                     chk("out_sel", {31'd0, out_sel}, {31'd0, e.sel});
                  end
               end else begin
                  vectors++; errors++;
                  $display("FAIL unexpected_output at edge %0d: wb_en=%b done=%b addr=%h expected none",
                           edge_cnt, wb_en, done, wb_addr);
               end
            end
            if (wb_en !== 1'b1 && busy === 1'b0)
               chk("out_sel_idle", {31'd0, out_sel}, 32'd0);
         end
      end
   end

   initial begin
      start = 1'b0; rst_f = 1'b0; rs_addr = '0; rt_addr = '0; rs_data = '0; rt_data = '0;
      // Reset for two cycles, then check every output is cleared.
      cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0);
      mon_en = 1'b1;
      cyc(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_out_sel", {31'd0, out_sel}, 32'd0);
      chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      idle(2);

      // Basic swap, with inputs changed right after the request.
      cyc(1'b1, 1'b1, 4'd3, 4'd7, 32'h1111_1111, 32'h2222_2222);
      cyc(1'b0, 1'b1, 4'd3, 4'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      idle(4);

      // Equal addresses: no writes, done one cycle after.
      cyc(1'b1, 1'b1, 4'd5, 4'd5, 32'hAAAA_0001, 32'hBBBB_0002);
      idle(3);

      // Start while busy is ignored.
      cyc(1'b1, 1'b1, 4'd3, 4'd7, 32'h1111_1111, 32'h2222_2222);
      cyc(1'b1, 1'b1, 4'd1, 4'd2, 32'h3333_3333, 32'h4444_4444);
      idle(5);

      // Reset mid-swap aborts.
      cyc(1'b1, 1'b1, 4'd3, 4'd7, 32'h1111_1111, 32'h2222_2222);
      cyc(1'b0, 1'b0, 4'd3, 4'd7, 32'h1111_1111, 32'h2222_2222);
      idle(5);

      // Register 0 as rs.
      cyc(1'b1, 1'b1, 4'd0, 4'd9, 32'h0000_00A0, 32'h0000_00B9);
      idle(5);

      // Randomized traffic, including back-to-back requests and rare resets.
      for (int i = 0; i < 600; i++) begin
         logic [ADDR_W-1:0] a1, a2;
         a1 = 4'($urandom_range(15, 0));
         a2 = ($urandom_range(3, 0) == 0) ? a1 : 4'($urandom_range(15, 0));
         cyc(1'($urandom_range(1, 0)), ($urandom_range(39, 0) != 0), a1, a2,
             $urandom, $urandom);
      end
      idle(6);

      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d events still pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/swap_wb_ctrl.md
Name: swap_wb_ctrl

Overview:
- Sequencer that performs a two-register swap through the single register-file write port.
- On a swap request it snapshots both operands and issues two back-to-back write-back cycles: rs <- old rt, then rt <- old rs.
- Drives the rs/rt select line for the swap data mux, plus the write address, data and enable toward the register file.
- Snapshots are required because the first write changes the value of rs before the second write occurs.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 4, width of register address (16 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_f  input  1  reset; synchronous, active-low.
- start  input  1  swap request; sampled only in IDLE.
- rs_addr  input  ADDR_W  first register address.
- rt_addr  input  ADDR_W  second register address.
- rs_data  input  DATA_W  current contents of rs; valid with start.
- rt_data  input  DATA_W  current contents of rt; valid with start.
- busy  output  1  high while a swap is in progress (any state other than IDLE).
- done  output  1  one-cycle completion pulse.
- out_sel  output  1  swap data mux select: 1 = rt data, 0 = rs data.
- wb_en  output  1  register-file write enable.
- wb_addr  output  ADDR_W  register-file write address.
- wb_data  output  DATA_W  register-file write data (the snapshot value selected by out_sel).

Behaviour:
- All outputs are registered.
- Reset: when rst_f=0 at a clock edge, the block goes to IDLE and clears all outputs (busy, done, out_sel, wb_en, wb_addr, wb_data) and all snapshot registers to 0.
- Reset mid-swap aborts the swap at that edge. No further wb_en pulse is issued, and done is not asserted.
- States: IDLE, WR_RS, WR_RT, DONE.
- IDLE:
  - outputs are 0.
  - start=1 at edge N: latch rs_addr, rt_addr, rs_data and rt_data into snapshots.
  - next state is WR_RS, or DONE if rs_addr==rt_addr.
- WR_RS (cycle N+1): wb_en=1, wb_addr=rs snapshot addr, out_sel=1, wb_data=rt snapshot, busy=1. Next state is WR_RT.
- WR_RT (cycle N+2): wb_en=1, wb_addr=rt snapshot addr, out_sel=0, wb_data=rs snapshot, busy=1. Next state is DONE.
- DONE (cycle N+3): done=1, busy=1, wb_en=0. Next state is IDLE.
- Latency: start edge to done pulse is 3 cycles; 4 cycles from start to ready for the next start.
- Equal addresses (rs_addr==rt_addr): no writes are issued, and done is asserted in cycle N+1. The swap is a no-op.
- start asserted while busy=1 is ignored. No queuing; no error indication.
- Input changes after edge N have no effect; only snapshots are used.
- out_sel holds its last value only while wb_en=1. It returns to 0 in DONE and IDLE.
- Snapshot data is passed unmodified, with no width conversion.

Optional Feature:
- Macro: SWAP_PROTECT_R0_EN.
- Defined: any write-back cycle whose address is 0 is suppressed.
  - wb_en stays 0 for that cycle.
  - wb_addr, wb_data and out_sel are still driven as normal.
  - State timing is unchanged, and done still pulses at N+3.
- Undefined: writes to address 0 are issued like any other address.

Test Plan:
- Reset then idle: hold rst_f=0 for 2 cycles, release -> all outputs 0, busy=0, no wb_en.
- Basic swap: start with rs_addr=3, rt_addr=7, rs_data=0x11111111, rt_data=0x22222222 ->
  - N+1: wb_en=1, wb_addr=3, wb_data=0x22222222, out_sel=1.
  - N+2: wb_en=1, wb_addr=7, wb_data=0x11111111, out_sel=0.
  - N+3: done=1.
- Snapshot integrity: same as the basic swap, but change rs_data/rt_data to 0xDEADBEEF at N+1 -> write data remain 0x22222222 / 0x11111111.
- Equal address: start with rs_addr=rt_addr=5 -> wb_en never asserted; done=1 at N+1; busy=0 at N+2.
- Busy and abort:
  - Re-assert start at N+1 with rs_addr=1, rt_addr=2 -> ignored; only the addr 3/7 writes occur.
  - Separately, drive rst_f=0 at N+1 -> wb_en=0 from N+2 onward, no done.
- R0 protect: with SWAP_PROTECT_R0_EN defined, swap rs_addr=0, rt_addr=9 -> wb_en=0 at N+1; wb_en=1, wb_addr=9 at N+2; done at N+3. Without the macro, both writes occur.
